// File: rtl/module_multiplication_if.sv
// Start/done handshake bundle for the sequential 8x8 multiplier.
// master = sequencer side, slave = multiplier side.
interface module_multiplication_if;
    logic        start;
    logic [7:0]  i_multiplicand;
    logic [7:0]  i_multiplier;
    logic [15:0] o_product;
    logic        o_ovf;
    logic        done;
    logic        busy;

    modport master (
        output start, i_multiplicand, i_multiplier,
        input  o_product, o_ovf, done, busy
    );

    modport slave (
        input  start, i_multiplicand, i_multiplier,
        output o_product, o_ovf, done, busy
    );
endinterface

// File: rtl/module_multiplication.sv
// Sequential 8x8 unsigned shift-add multiplier, one multiplier bit per clock.
// Optional MULT_EARLY_EXIT_EN: stop iterating once no multiplier bits remain.
module module_multiplication (
    input  logic                          clk,
    input  logic                          rst_n,
    module_multiplication_if.slave        bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] acc_reg;
    logic [15:0] mcand_reg;
    logic [7:0]  mplier_reg;
    logic [3:0]  count_reg;
    logic [15:0] product_reg;
    logic        ovf_reg;
    logic        done_reg;
    logic        busy_reg;

    logic [15:0] partial_next;
    logic [7:0]  mplier_next;
    logic        last_iter;

    assign partial_next = mplier_reg[0] ? mcand_reg : 16'h0000;
    assign mplier_next  = mplier_reg >> 1;

`ifdef MULT_EARLY_EXIT_EN
    // Remaining multiplier bits all zero means further adds contribute nothing.
    assign last_iter = (count_reg == 4'd1) || (mplier_next == 8'h00);
`else
    assign last_iter = (count_reg == 4'd1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            acc_reg     <= 16'h0000;
            mcand_reg   <= 16'h0000;
            mplier_reg  <= 8'h00;
            count_reg   <= 4'd0;
            product_reg <= 16'h0000;
            ovf_reg     <= 1'b0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        acc_reg    <= 16'h0000;
                        mcand_reg  <= {8'h00, bus.i_multiplicand};
                        mplier_reg <= bus.i_multiplier;
                        count_reg  <= 4'd8;
                        busy_reg   <= 1'b1;
                        state_reg  <= CALC;
                    end
                end
                CALC: begin
                    // 8x8 product fits in 16 bits, so the add never carries out.
                    acc_reg    <= acc_reg + partial_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_next;
                    count_reg  <= count_reg - 4'd1;
                    if (last_iter) begin
                        state_reg <= FINISH;
                    end
                end
                FINISH: begin
                    product_reg <= acc_reg;
                    ovf_reg     <= |acc_reg[15:8];
                    done_reg    <= 1'b1;
                    busy_reg    <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_product = product_reg;
    assign bus.o_ovf     = ovf_reg;
    assign bus.done      = done_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_module_multiplication.sv
// Self-checking bench for module_multiplication: directed test-plan steps
// plus random operands against an arithmetic reference model.
module tb_module_multiplication;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    module_multiplication_if bus ();

    module_multiplication dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Cycles from the accepting edge to the edge after which done is visible.
    function automatic int exp_lat(input logic [7:0] b);
`ifdef MULT_EARLY_EXIT_EN
        int it;
        it = 1;
        for (int i = 0; i < 8; i++) if (b[i]) it = i + 1;
        return it + 1;
`else
        return 9;
`endif
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [15:0] prev;
        logic [15:0] expp;
        int lat;
        int k;
        bit got;
        prev = bus.o_product;
        expp = 16'(a) * 16'(b);
        lat  = exp_lat(b);
        bus.i_multiplicand = a;
        bus.i_multiplier   = b;
        bus.start          = 1'b1;
        tick;
        bus.start          = 1'b0;
        bus.i_multiplicand = $urandom;
        bus.i_multiplier   = $urandom;
        chk({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
        k = 0;
        got = 0;
        while (!got && k < 20) begin
            tick;
            k++;
            if (bus.done) got = 1;
            else begin
                if (k < lat) chk({tag, "_busy_mid"}, 32'(bus.busy), 32'd1);
                chk({tag, "_hold"}, 32'(bus.o_product), 32'(prev));
            end
        end
        chk({tag, "_latency"}, 32'(k), 32'(lat));
        chk({tag, "_product"}, 32'(bus.o_product), 32'(expp));
        chk({tag, "_ovf"}, 32'(bus.o_ovf), 32'(expp > 16'd255));
        chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        tick;
        chk({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int dones;
        int busy_cycles;
        int last_done;
        int intervals_bad;
        logic [15:0] v;

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.i_multiplicand = 8'h00;
        bus.i_multiplier   = 8'h00;
        repeat (2) tick;
        chk("rst_product", 32'(bus.o_product), 32'h0);
        chk("rst_ovf", 32'(bus.o_ovf), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;
        tick;

        run_op(8'd13, 8'd11, "t13x11");
        run_op(8'd200, 8'd2, "t200x2");
        run_op(8'd0, 8'd0, "t0x0");
        run_op(8'd1, 8'd1, "t1x1");

        // 255x255 with busy duration measured separately
        bus.i_multiplicand = 8'd255;
        bus.i_multiplier   = 8'd255;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.busy) busy_cycles++;
            tick;
        end
        chk("t255_busy_cycles", 32'(busy_cycles), 32'd9);
        chk("t255_product", 32'(bus.o_product), 32'hFE01);
        chk("t255_ovf", 32'(bus.o_ovf), 32'd1);

        // Start re-pulsed during CALC must be ignored.
        bus.i_multiplicand = 8'd3;
        bus.i_multiplier   = 8'd5;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        dones = 0;
        tick;
        bus.i_multiplicand = 8'd7;
        bus.i_multiplier   = 8'd7;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) dones++;
            tick;
        end
        chk("ign_done_count", 32'(dones), 32'd1);
        chk("ign_product", 32'(bus.o_product), 32'h000F);
        run_op(8'd7, 8'd7, "t7x7");

        // Reset asserted mid-operation.
        bus.i_multiplicand = 8'd255;
        bus.i_multiplier   = 8'd255;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (3) tick;
        rst_n = 1'b0;
        #1;
        chk("mrst_product", 32'(bus.o_product), 32'h0);
        chk("mrst_busy", 32'(bus.busy), 32'h0);
        tick;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.done) dones++;
            tick;
        end
        chk("mrst_no_done", 32'(dones), 32'd0);
        chk("mrst_product_after", 32'(bus.o_product), 32'h0);
        chk("mrst_ovf_after", 32'(bus.o_ovf), 32'h0);
        run_op(8'd16, 8'd16, "t16x16");

        // Random operands against the arithmetic model.
        for (int n = 0; n < 20; n++) begin
            run_op(8'($urandom), 8'($urandom_range(255, 0) >> $urandom_range(7, 0)), "rand");
        end

        // start held high: one result per (latency + 1) cycles.
        bus.i_multiplicand = 8'd2;
        bus.i_multiplier   = 8'd3;
        bus.start = 1'b1;
        dones = 0;
        last_done = -1;
        intervals_bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (bus.done) begin
                dones++;
                v = bus.o_product;
                chk("held_product", 32'(v), 32'h0006);
                if (last_done >= 0 && (i - last_done) != exp_lat(8'd3) + 1) intervals_bad++;
                last_done = i;
            end
        end
        bus.start = 1'b0;
        chk("held_min_dones", 32'(dones >= 2), 32'd1);
        chk("held_interval", 32'(intervals_bad), 32'd0);
        repeat (12) tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
